// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader
//   Front end of the measurement path. Each XADC end-of-conversion starts one
//   DRP read. The returned word is presented on xadc_data together with a
//   one-cycle data_valid pulse. One EOC that arrives during a read is held as
//   pending; a further EOC overwrites it and flags overrun. A read that gets no
//   drdy within TIMEOUT_CYCLES is abandoned and flags timeout_err.
//
// Ports
//   clock, reset    rising-edge clock, synchronous active-high reset
//   enable          gates new reads; when low, pending is dropped and eoc ignored
//   clear_err       clears timeout_err / overrun (wins over a same-cycle set)
//   eoc, channel    XADC end-of-conversion pulse and its channel number
//   drdy, drp_do    DRP read response
//   den, daddr      DRP request (den is one cycle per read, daddr valid with it)
//   dwe, di         tied to zero (read only)
//   xadc_data       last successfully read word
//   data_valid      one-cycle pulse when xadc_data is new
//   busy            a read is in flight
//   timeout_err     sticky: a read timed out
//   overrun         sticky: an EOC was lost
//   sample_count    number of data_valid pulses, mod 2^16

module xadc_drp_reader #(
    parameter logic [6:0]  CHANNEL_ADDR   = 7'h03,
    parameter int unsigned ADDR_MODE      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_err,
    input  logic        eoc,
    input  logic [4:0]  channel,
    input  logic        drdy,
    input  logic [15:0] drp_do,
    output logic        den,
    output logic [6:0]  daddr,
    output logic        dwe,
    output logic [15:0] di,
    output logic [15:0] xadc_data,
    output logic        data_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun,
    output logic [15:0] sample_count
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    // Counter value on the last WAIT cycle that may still accept drdy.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [4:0]  pend_chan_q, pend_chan_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;

    function automatic logic [6:0] chan_to_addr(input logic [4:0] ch);
        if (ADDR_MODE != 0) begin
            return {2'b00, ch};
        end
        return CHANNEL_ADDR;
    endfunction

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pend_chan_d = pend_chan_q;
        addr_d      = addr_q;
        tmo_cnt_d   = tmo_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        count_d     = count_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (enable && (eoc || pending_q)) begin
                    state_d   = StReq;
                    pending_d = 1'b0;
                    // A fresh EOC is the newest conversion, so it takes precedence.
                    addr_d    = eoc ? chan_to_addr(channel) : chan_to_addr(pend_chan_q);
                end
            end
            StReq: begin
                tmo_cnt_d = '0;
                state_d   = StWait;
            end
            StWait: begin
                if (drdy) begin
                    data_d  = drp_do;
                    valid_d = 1'b1;
                    count_d = count_q + 16'd1;
                    state_d = StIdle;
                end else if (tmo_cnt_q == TmoLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Queue one EOC while busy; a second one replaces it and is an overrun.
        if (enable && eoc && (state_q != StIdle)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end
            pending_d   = 1'b1;
            pend_chan_d = channel;
        end

        if (!enable) begin
            pending_d = 1'b0;
        end

        if (clear_err) begin
            timeout_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            pend_chan_q <= '0;
            addr_q      <= '0;
            tmo_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            count_q     <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pend_chan_q <= pend_chan_d;
            addr_q      <= addr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign den          = (state_q == StReq);
    assign daddr        = addr_q;
    assign dwe          = 1'b0;
    assign di           = '0;
    assign xadc_data    = data_q;
    assign data_valid   = valid_q;
    assign busy         = (state_q != StIdle);
    assign timeout_err  = timeout_q;
    assign overrun      = overrun_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Bench for xadc_drp_reader: two instances (fixed address / channel address)
// share all stimulus and are compared every cycle against one transaction-level
// model of the read flow, with directed scenarios followed by random traffic.

module tb_xadc_drp_reader;

    localparam int unsigned T = 8;

    logic        clock = 1'b0;
    logic        reset, enable, clear_err, eoc, drdy;
    logic [4:0]  channel;
    logic [15:0] drp_do;

    logic        den [2];
    logic [6:0]  daddr [2];
    logic        dwe [2];
    logic [15:0] di [2];
    logic [15:0] xadc_data [2];
    logic        data_valid [2];
    logic        busy [2];
    logic        timeout_err [2];
    logic        overrun [2];
    logic [15:0] sample_count [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    xadc_drp_reader #(.CHANNEL_ADDR(7'h03), .ADDR_MODE(0), .TIMEOUT_CYCLES(T)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .clear_err(clear_err), .eoc(eoc),
        .channel(channel), .drdy(drdy), .drp_do(drp_do), .den(den[0]), .daddr(daddr[0]),
        .dwe(dwe[0]), .di(di[0]), .xadc_data(xadc_data[0]), .data_valid(data_valid[0]),
        .busy(busy[0]), .timeout_err(timeout_err[0]), .overrun(overrun[0]),
        .sample_count(sample_count[0])
    );

    xadc_drp_reader #(.CHANNEL_ADDR(7'h03), .ADDR_MODE(1), .TIMEOUT_CYCLES(T)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .clear_err(clear_err), .eoc(eoc),
        .channel(channel), .drdy(drdy), .drp_do(drp_do), .den(den[1]), .daddr(daddr[1]),
        .dwe(dwe[1]), .di(di[1]), .xadc_data(xadc_data[1]), .data_valid(data_valid[1]),
        .busy(busy[1]), .timeout_err(timeout_err[1]), .overrun(overrun[1]),
        .sample_count(sample_count[1])
    );

    // Reference model: a read is "active" from its request cycle until it
    // completes; m_age counts edges since the request (0 = request cycle).
    bit          m_active;
    int          m_age;
    int          m_pend[$];
    logic [6:0]  m_addr [2];
    logic [15:0] m_data;
    bit          m_valid;
    int          m_count;
    bit          m_tmo, m_ovr;

    task automatic model_step();
        bit start;
        int ch_sel;
        if (reset) begin
            m_active = 0; m_age = 0; m_pend.delete();
            m_addr[0] = '0; m_addr[1] = '0; m_data = '0;
            m_valid = 0; m_count = 0; m_tmo = 0; m_ovr = 0;
            return;
        end
        m_valid = 0;
        start = !m_active && enable && (eoc || m_pend.size() > 0);
        if (m_active) begin
            if (enable && eoc) begin
                if (m_pend.size() > 0) begin
                    m_ovr = 1;
                    m_pend.delete();
                end
                m_pend.push_back(int'(channel));
            end
            if (m_age == 0) begin
                m_age = 1;
            end else if (drdy) begin
                m_data = drp_do; m_valid = 1; m_count = (m_count + 1) % 65536; m_active = 0;
            end else if (m_age == int'(T)) begin
                m_tmo = 1; m_active = 0;
            end else begin
                m_age++;
            end
        end
        if (!enable) m_pend.delete();
        if (start) begin
            ch_sel = eoc ? int'(channel) : m_pend[0];
            m_pend.delete();
            m_addr[0] = 7'h03;
            m_addr[1] = 7'(ch_sel);
            m_active = 1;
            m_age = 0;
        end
        if (clear_err) begin
            m_tmo = 0; m_ovr = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit exp_den;
        exp_den = m_active && (m_age == 0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("den%0d", d), 32'(den[d]), 32'(exp_den));
            if (exp_den) check($sformatf("daddr%0d", d), 32'(daddr[d]), 32'(m_addr[d]));
            check($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_active));
            check($sformatf("valid%0d", d), 32'(data_valid[d]), 32'(m_valid));
            check($sformatf("data%0d", d), 32'(xadc_data[d]), 32'(m_data));
            check($sformatf("tmo%0d", d), 32'(timeout_err[d]), 32'(m_tmo));
            check($sformatf("ovr%0d", d), 32'(overrun[d]), 32'(m_ovr));
            check($sformatf("count%0d", d), 32'(sample_count[d]), 32'(m_count));
            check($sformatf("dwe%0d", d), 32'(dwe[d]), 32'd0);
            check($sformatf("di%0d", d), 32'(di[d]), 32'd0);
        end
    endtask

    // Inputs change 1 time unit after the edge; the model samples at the edge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1; enable = 0; clear_err = 0; eoc = 0; channel = '0; drdy = 0; drp_do = '0;
        cycle();
        cycle();
        check("rst_den", 32'(den[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_data", 32'(xadc_data[0]), 32'd0);
        check("rst_count", 32'(sample_count[0]), 32'd0);
        check("rst_daddr", 32'(daddr[1]), 32'd0);

        // Basic read, response three cycles after den.
        reset = 0; enable = 1; eoc = 1; channel = 5'h11;
        cycle();
        check("a_den", 32'(den[0]), 32'd1);
        check("a_daddr0", 32'(daddr[0]), 32'h03);
        check("a_daddr1", 32'(daddr[1]), 32'h11);
        eoc = 0;
        cycle();
        check("a_den_single", 32'(den[0]), 32'd0);
        cycle();
        cycle();
        drdy = 1; drp_do = 16'hFFC0;
        cycle();
        check("a_data", 32'(xadc_data[0]), 32'hFFC0);
        check("a_valid", 32'(data_valid[0]), 32'd1);
        check("a_count", 32'(sample_count[0]), 32'd1);
        drdy = 0;
        cycle();
        check("a_valid_pulse", 32'(data_valid[0]), 32'd0);

        // Pending EOC, then overrun with newest channel winning.
        eoc = 1; channel = 5'd1;
        cycle();
        channel = 5'd2;
        cycle();
        eoc = 0;
        cycle();
        drdy = 1;
        cycle();
        drdy = 0;
        cycle();
        check("b_den2", 32'(den[1]), 32'd1);
        check("b_daddr2", 32'(daddr[1]), 32'd2);
        check("b_no_ovr", 32'(overrun[0]), 32'd0);
        cycle();
        eoc = 1; channel = 5'd4;
        cycle();
        channel = 5'd5;
        cycle();
        eoc = 0;
        check("b_ovr", 32'(overrun[0]), 32'd1);
        drdy = 1;
        cycle();
        drdy = 0;
        cycle();
        check("b_newest", 32'(daddr[1]), 32'd5);
        cycle();
        drdy = 1; drp_do = 16'h1234;
        cycle();
        drdy = 0; clear_err = 1;
        cycle();
        clear_err = 0;
        check("b_clear", 32'(overrun[0]), 32'd0);

        // Timeout with no response, late drdy ignored.
        eoc = 1; channel = 5'd0;
        cycle();
        eoc = 0;
        for (int i = 0; i < int'(T); i++) cycle();
        check("c_tmo_early", 32'(timeout_err[0]), 32'd0);
        cycle();
        check("c_tmo", 32'(timeout_err[0]), 32'd1);
        check("c_data_kept", 32'(xadc_data[0]), 32'h1234);
        drdy = 1; drp_do = 16'hBEEF;
        cycle();
        check("c_late_valid", 32'(data_valid[0]), 32'd0);
        check("c_late_data", 32'(xadc_data[0]), 32'h1234);
        drdy = 0; clear_err = 1;
        cycle();
        clear_err = 0;
        check("c_clear", 32'(timeout_err[0]), 32'd0);

        // Reset during WAIT, then a stray response.
        eoc = 1;
        cycle();
        eoc = 0;
        cycle();
        reset = 1;
        cycle();
        reset = 0; drdy = 1; drp_do = 16'hAAAA;
        cycle();
        check("d_valid", 32'(data_valid[0]), 32'd0);
        check("d_data", 32'(xadc_data[0]), 32'd0);
        check("d_count", 32'(sample_count[0]), 32'd0);
        check("d_busy", 32'(busy[0]), 32'd0);
        drdy = 0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            enable    = ($urandom_range(0, 15) != 0);
            clear_err = ($urandom_range(0, 29) == 0);
            eoc       = ($urandom_range(0, 5) == 0);
            channel   = 5'($urandom);
            drdy      = ($urandom_range(0, 3) == 0);
            drp_do    = 16'($urandom);
            cycle();
        end

        // Sample counter wrap.
        reset = 0; enable = 1; clear_err = 0; eoc = 0; drdy = 0;
        repeat (12) cycle();
        force dut0.count_q = 16'hFFFF;
        force dut1.count_q = 16'hFFFF;
        #1;
        release dut0.count_q;
        release dut1.count_q;
        m_count = 16'hFFFF;
        cycle();
        eoc = 1;
        cycle();
        eoc = 0;
        cycle();
        drdy = 1;
        cycle();
        drdy = 0;
        check("e_wrap0", 32'(sample_count[0]), 32'd0);
        check("e_wrap1", 32'(sample_count[1]), 32'd0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xadc_drp_reader.md
# xadc_drp_reader

Front-end stage of the regulator's measurement path. It watches the XADC end-of-conversion strobe, runs one DRP read per conversion, and presents the raw 16-bit status-register word as `xadc_data` with a one-cycle `data_valid` pulse to the voltage conversion stage (`voltage_data`). It also detects missing DRP responses and conversions that arrive while a read is still in progress, and counts delivered samples.

## Interface
Parameters:
- `CHANNEL_ADDR`, 7'h03, fixed DRP address to read when `ADDR_MODE`=0 (VP/VN status register).
- `ADDR_MODE`, 0, 0 = always read `CHANNEL_ADDR`; 1 = read {2'b00, `channel`} captured at the EOC that triggered the read.
- `TIMEOUT_CYCLES`, 64, cycles to wait for `drdy` after `den` before aborting; legal range 2..255.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  when low, new reads are not started and a pending request is dropped.
- `clear_err`  in  1  synchronous clear of `timeout_err` and `overrun`.
- `eoc`  in  1  XADC end-of-conversion, one-cycle pulse.
- `channel`  in  5  XADC channel number, valid with `eoc`.
- `drdy`  in  1  DRP data ready.
- `drp_do`  in  16  DRP read data.
- `den`  out  1  DRP enable, exactly one cycle per read.
- `daddr`  out  7  DRP address, valid while `den`=1.
- `dwe`  out  1  constant 0.
- `di`  out  16  constant 0.
- `xadc_data`  out  16  last successfully read word.
- `data_valid`  out  1  one-cycle pulse; `xadc_data` is new.
- `busy`  out  1  high in REQ or WAIT.
- `timeout_err`  out  1  sticky; a read timed out.
- `overrun`  out  1  sticky; an EOC was lost.
- `sample_count`  out  16  number of `data_valid` pulses since reset, mod 2^16.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: if `enable` and (`eoc` or `pending`), go to REQ and clear `pending`. Latch the address from `channel` (if `eoc`) or from the stored channel (if `pending`).
- REQ: `den`=1 and `daddr`=latched address for this one cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - `drdy`=1: capture `drp_do` into `xadc_data`, pulse `data_valid` on the next cycle, increment `sample_count` (0xFFFF wraps to 0x0000), go to IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`-1 with no `drdy`: set `timeout_err`, go to IDLE, leave `xadc_data` unchanged, no `data_valid` pulse.
- `eoc` in REQ or WAIT with `enable`=1:
  - If `pending`=0: set `pending` and store `channel`.
  - If `pending` is already 1: set `overrun` and overwrite the stored channel (newest wins).
- `drdy` in IDLE or REQ is ignored. This covers a late response after a timeout.
- `enable`=0: `pending` is cleared and `eoc` is ignored. An in-flight read still completes normally.
- `clear_err` has priority over a same-cycle set: both flags read 0 on the next cycle.
- Reset (any state, including mid-read):
  - State goes to IDLE; `den`, `data_valid`, `busy`, `pending`, `timeout_err`, `overrun` = 0.
  - `xadc_data` = 16'h0000, `sample_count` = 0, `daddr` = 0.
  - A `drdy` arriving after reset is ignored.

## Timing
- `eoc` sampled high at edge k (in IDLE): `den`=1 during cycle k+1, `busy`=1 from k+1.
- `drdy` sampled at edge m (m ≥ k+2): `xadc_data` and `data_valid` are visible after edge m; `busy`=0 after edge m.
- Minimum EOC-to-`data_valid` latency: 2 cycles. Back-to-back reads through `pending`: next `den` 2 cycles after `drdy`.
- `data_valid` is never high for two consecutive cycles.
- `timeout_err` rises `TIMEOUT_CYCLES` cycles after the `den` cycle.

## Test plan
- Reset, then `eoc` with `drdy` returning 3 cycles after `den` and `drp_do`=16'hFFC0 -> `den` is a single cycle with `daddr`=7'h03; `xadc_data`=16'hFFC0; one `data_valid` pulse; `sample_count`=1.
- `ADDR_MODE`=1, `eoc` with `channel`=5'h11 -> `daddr`=7'h11.
- Second `eoc` during WAIT -> after the first `drdy`, a second `den` follows 2 cycles later; `overrun`=0. A third `eoc` in the same WAIT -> `overrun`=1.
- No `drdy`, `TIMEOUT_CYCLES`=8 -> `timeout_err`=1 eight cycles after `den`; `xadc_data` unchanged; a late `drdy` is ignored; `clear_err` returns `timeout_err` to 0.
- Reset asserted in WAIT, then `drdy` arrives -> all outputs at reset values; no `data_valid`.
- Preload `sample_count` to 16'hFFFF via 65535 reads (or force) -> the next read wraps it to 16'h0000.
